ifu_fetch: RTL and testbench

//  Instruction fetch unit: generates sequential/jump PCs, issues pipelined reads to instruction memory
//  (req/gnt/rvalid), buffers returned words in a DEPTH-entry FIFO and presents {pc, inst} to the
//  IF/ID pipeline register. Sits directly upstream of if_id_dff; honours ctrl hold and jump/flush.

---
 rtl/ifu_fetch.sv | 155 +++++++++++++++
 tb/tb_ifu_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: budgeted pipelined memory reads, response FIFO, {pc, inst} to IF/ID.
// Define IFU_PERF_CNT_EN to implement the delivered/dropped performance counters.
module ifu_fetch #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_jump_flag_i,
    input  logic [ADDR_WIDTH-1:0] ifu_jump_addr_i,
    input  logic                  ifu_hold_flag_i,
    output logic                  ifu_mem_req_o,
    output logic [ADDR_WIDTH-1:0] ifu_mem_addr_o,
    input  logic                  ifu_mem_gnt_i,
    input  logic                  ifu_mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] ifu_mem_rdata_i,
    output logic [ADDR_WIDTH-1:0] ifu_pc_o,
    output logic [DATA_WIDTH-1:0] ifu_inst_data_o,
    output logic                  ifu_inst_valid_o,
    output logic [31:0]           ifu_perf_fetch_cnt_o,
    output logic [31:0]           ifu_perf_drop_cnt_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]         outst_cnt_q, outst_cnt_d;
    logic [CW-1:0]         discard_cnt_q, discard_cnt_d;
    logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] fifo_pc_q   [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_inst_q [DEPTH];

    logic [CW:0]           budget;
    logic                  grant;
    logic                  rvalid_ok;
    logic                  drop;
    logic                  push;
    logic                  pop;
    logic                  fifo_nonempty;
    logic [ADDR_WIDTH-1:0] jump_tgt;
    logic                  unused_jump_lsbs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Outstanding requests reserve a FIFO slot, so a push can never find the FIFO full.
    assign budget        = {1'b0, outst_cnt_q} + {1'b0, fifo_cnt_q};
    assign ifu_mem_req_o = !rst && (budget < (CW + 1)'(DEPTH));
    assign ifu_mem_addr_o = fetch_pc_q;

    assign grant         = ifu_mem_req_o && ifu_mem_gnt_i;
    assign rvalid_ok     = ifu_mem_rvalid_i && (outst_cnt_q != '0);
    assign drop          = rvalid_ok && (ifu_jump_flag_i || (discard_cnt_q != '0));
    assign push          = rvalid_ok && !drop;
    assign fifo_nonempty = (fifo_cnt_q != '0);
    assign pop           = !ifu_jump_flag_i && !ifu_hold_flag_i && fifo_nonempty;
    assign jump_tgt      = {ifu_jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_jump_lsbs = ^ifu_jump_addr_i[1:0];

    always_comb begin
        outst_cnt_d   = outst_cnt_q + CW'(grant) - CW'(rvalid_ok);
        discard_cnt_d = discard_cnt_q;
        fifo_cnt_d    = fifo_cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fetch_pc_d    = grant ? fetch_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
        resp_pc_d     = push  ? resp_pc_q  + ADDR_WIDTH'(4) : resp_pc_q;
        if (drop && !ifu_jump_flag_i) begin
            discard_cnt_d = discard_cnt_q - CW'(1);
        end
        // Every request still in flight after this cycle (including a same-cycle grant) is stale;
        // earlier stale ones are already part of outst_cnt, so this is not added to discard_cnt.
        if (ifu_jump_flag_i) begin
            discard_cnt_d = outst_cnt_d;
            fifo_cnt_d    = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            fetch_pc_d    = jump_tgt;
            resp_pc_d     = jump_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outst_cnt_q   <= '0;
            discard_cnt_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outst_cnt_q   <= outst_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
            fifo_inst_q[wr_ptr_q] <= ifu_mem_rdata_i;
        end
    end

    always_comb begin
        ifu_inst_valid_o = !rst && fifo_nonempty;
        ifu_pc_o         = resp_pc_q;
        ifu_inst_data_o  = NOP_INST;
        if (rst) begin
            ifu_pc_o = RESET_PC;
        end else if (fifo_nonempty) begin
            ifu_pc_o        = fifo_pc_q[rd_ptr_q];
            ifu_inst_data_o = fifo_inst_q[rd_ptr_q];
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (pop) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (drop) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign ifu_perf_fetch_cnt_o = fetch_cnt_q;
    assign ifu_perf_drop_cnt_o  = drop_cnt_q;
`else
    assign ifu_perf_fetch_cnt_o = '0;
    assign ifu_perf_drop_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch (DEPTH=2) with a queue-based in-order memory responder.
module tb_ifu_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump = 1'b0;
    logic [31:0] jaddr = '0;
    logic        hold = 1'b0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        req_o;
    logic [31:0] addr_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic [31:0] fetch_cnt;
    logic [31:0] drop_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned ngrants = 0;
    bit          gnt_en  = 1'b1;
    bit          rsp_en  = 1'b1;
    logic [31:0] pendq [$];
    logic [63:0] deliv [$];

    always #5 clk = ~clk;

    ifu_fetch #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0),
        .DEPTH      (2),
        .NOP_INST   (NOP)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ifu_jump_flag_i      (jump),
        .ifu_jump_addr_i      (jaddr),
        .ifu_hold_flag_i      (hold),
        .ifu_mem_req_o        (req_o),
        .ifu_mem_addr_o       (addr_o),
        .ifu_mem_gnt_i        (gnt),
        .ifu_mem_rvalid_i     (rvalid),
        .ifu_mem_rdata_i      (rdata),
        .ifu_pc_o             (pc_o),
        .ifu_inst_data_o      (inst_o),
        .ifu_inst_valid_o     (valid_o),
        .ifu_perf_fetch_cnt_o (fetch_cnt),
        .ifu_perf_drop_cnt_o  (drop_cnt)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then log grants and deliveries.
    task automatic cyc(input logic r = 1'b0, input logic h = 1'b0,
                       input logic j = 1'b0, input logic [31:0] ja = '0);
        @(negedge clk);
        rst   = r;
        hold  = h;
        jump  = j;
        jaddr = ja;
        if (!r && rsp_en && pendq.size() > 0) begin
            rvalid = 1'b1;
            rdata  = inst_of(pendq.pop_front());
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        gnt = gnt_en;
        #1;
        if (req_o && gnt) begin
            pendq.push_back(addr_o);
            ngrants++;
        end
        if (valid_o && !h && !j && !r) begin
            deliv.push_back({pc_o, inst_o});
        end
    endtask

    task automatic reset_dut();
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        cyc(1'b1);
        pendq.delete();
        deliv.delete();
        ngrants = 0;
        cyc(1'b1);
    endtask

    initial begin
        // Reset values
        reset_dut();
        check("rst_req",   {63'd0, req_o},   64'd0);
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_inst",  {32'd0, inst_o},  {32'd0, NOP});
        check("rst_pc",    {32'd0, pc_o},    64'd0);
        check("rst_fcnt",  {32'd0, fetch_cnt}, 64'd0);
        check("rst_dcnt",  {32'd0, drop_cnt},  64'd0);

        // Streaming fetch, 1-cycle memory
        cyc();
        check("t1_addr0", {32'd0, addr_o}, 64'd0);
        check("t1_req0",  {63'd0, req_o},  64'd1);
        cyc();
        check("t1_c1_valid", {63'd0, valid_o}, 64'd0);
        cyc();
        check("t1_c2_valid", {63'd0, valid_o}, 64'd1);
        check("t1_c2_pc",    {32'd0, pc_o},    64'd0);
        check("t1_c2_inst",  {32'd0, inst_o},  {32'd0, inst_of(32'h0)});
        for (int i = 0; i < 10; i++) cyc();
        check("t1_ndeliv", {63'd0, deliv.size() == 8}, 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("t1_seq_pc",   {32'd0, deliv[k][63:32]}, {32'd0, 32'(4 * k)});
            check("t1_seq_inst", {32'd0, deliv[k][31:0]},  {32'd0, inst_of(32'(4 * k))});
        end
        cyc(1'b0, 1'b1);
`ifdef IFU_PERF_CNT_EN
        check("t1_fcnt", {32'd0, fetch_cnt}, 64'd8);
`else
        check("t1_fcnt", {32'd0, fetch_cnt}, 64'd0);
`endif

        // Hold fills the budget, then release
        reset_dut();
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1);
        check("t2_grants", 64'(ngrants), 64'd2);
        check("t2_req",    {63'd0, req_o},   64'd0);
        check("t2_valid",  {63'd0, valid_o}, 64'd1);
        check("t2_pc",     {32'd0, pc_o},    64'd0);
        cyc();
        cyc();
        check("t2_req_resume",  {63'd0, req_o}, 64'd1);
        check("t2_addr_resume", {32'd0, addr_o}, 64'h8);
        check("t2_pc4",         {32'd0, pc_o},   64'h4);
        check("t2_ndeliv",      64'(deliv.size()), 64'd2);
        check("t2_d0",          {32'd0, deliv[0][63:32]}, 64'h0);

        // Two outstanding, then jump to 0x100
        reset_dut();
        rsp_en = 1'b0;
        cyc();
        cyc();
        cyc(1'b0, 1'b0, 1'b1, 32'h100);
        check("t3_req_full", {63'd0, req_o}, 64'd0);
        rsp_en = 1'b1;
        cyc();
        check("t3_valid_after_jump", {63'd0, valid_o}, 64'd0);
        check("t3_pc_empty",         {32'd0, pc_o},    64'h100);
        cyc();
        check("t3_addr", {32'd0, addr_o}, 64'h100);
        cyc();
        cyc();
        check("t3_valid", {63'd0, valid_o}, 64'd1);
        check("t3_pc",    {32'd0, pc_o},    64'h100);
        check("t3_inst",  {32'd0, inst_o},  {32'd0, inst_of(32'h100)});
        check("t3_nostale", 64'(deliv.size()), 64'd1);
`ifdef IFU_PERF_CNT_EN
        check("t3_dcnt", {32'd0, drop_cnt}, 64'd2);
`else
        check("t3_dcnt", {32'd0, drop_cnt}, 64'd0);
`endif

        // Unaligned jump target with a same-cycle stale grant
        reset_dut();
        cyc(1'b0, 1'b0, 1'b1, 32'h203);
        cyc();
        check("t4_addr",  {32'd0, addr_o}, 64'h200);
        check("t4_pc",    {32'd0, pc_o},   64'h200);
        check("t4_valid", {63'd0, valid_o}, 64'd0);
        cyc();
        cyc();
        check("t4_first_pc",   {32'd0, pc_o},   64'h200);
        check("t4_first_inst", {32'd0, inst_o}, {32'd0, inst_of(32'h200)});

        // Grant withheld
        reset_dut();
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t5_req",   {63'd0, req_o},   64'd1);
            check("t5_addr",  {32'd0, addr_o},  64'd0);
            check("t5_valid", {63'd0, valid_o}, 64'd0);
            check("t5_inst",  {32'd0, inst_o},  {32'd0, NOP});
        end
        gnt_en = 1'b1;
        cyc();
        cyc();
        cyc();
        check("t5_late_pc", {32'd0, pc_o}, 64'd0);
        check("t5_late_valid", {63'd0, valid_o}, 64'd1);

        // Jump coincident with rvalid under hold
        reset_dut();
        rsp_en = 1'b0;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        rsp_en = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 32'h300);
        cyc(1'b0, 1'b1);
        check("t6_valid", {63'd0, valid_o}, 64'd0);
        check("t6_pc",    {32'd0, pc_o},    64'h300);
        check("t6_inst",  {32'd0, inst_o},  {32'd0, NOP});
        check("t6_addr",  {32'd0, addr_o},  64'h300);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        check("t6_held_pc",   {32'd0, pc_o},   64'h300);
        check("t6_held_inst", {32'd0, inst_o}, {32'd0, inst_of(32'h300)});
`ifdef IFU_PERF_CNT_EN
        check("t6_dcnt", {32'd0, drop_cnt}, 64'd2);
`else
        check("t6_dcnt", {32'd0, drop_cnt}, 64'd0);
`endif
        cyc();
        cyc();
        check("t6_ndeliv", 64'(deliv.size()), 64'd2);
        check("t6_d0", {32'd0, deliv[0][63:32]}, 64'h300);
        check("t6_d1", {32'd0, deliv[1][63:32]}, 64'h304);

        // Flush of a full FIFO under hold, jump near the top of the address space
        reset_dut();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
        check("t7_full_req",   {63'd0, req_o},   64'd0);
        check("t7_full_valid", {63'd0, valid_o}, 64'd1);
        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        cyc(1'b0, 1'b1);
        check("t7_flush_valid", {63'd0, valid_o}, 64'd0);
        check("t7_pc",          {32'd0, pc_o},    64'hFFFF_FFFC);
        check("t7_addr",        {32'd0, addr_o},  64'hFFFF_FFFC);
        cyc(1'b0, 1'b1);
        check("t7_wrap_addr",   {32'd0, addr_o},  64'h0);
        cyc(1'b0, 1'b1);
        check("t7_wrap_head",   {32'd0, pc_o},    64'hFFFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
